// File: rtl/adder_slice.sv
// adder_slice: W-bit combinational ripple adder, one carry-chain slice.
// Ports: a, b operands; ci carry in; s sum; co carry out.
module adder_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep carry-chain adder/subtractor, valid/ready.
// Ports: CLK, RST (async low); A, B, Carry_in, Sub, In_valid/In_ready in;
//        Sum, Carry_out, Overflow, Out_valid/Out_ready out.
module pipelined_adder #(
  parameter int DATA_WIDTH = 16,
  parameter int STAGES     = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  Carry_in,
  input  logic                  Sub,
  input  logic                  In_valid,
  output logic                  In_ready,
  output logic [DATA_WIDTH-1:0] Sum,
  output logic                  Carry_out,
  output logic                  Overflow,
  output logic                  Out_valid,
  input  logic                  Out_ready
);

  localparam int W = DATA_WIDTH / STAGES;

  if (STAGES < 1 || (DATA_WIDTH % STAGES) != 0) begin : g_chk
    $error("DATA_WIDTH must be a multiple of STAGES");
  end

  logic advance;

  assign advance  = !Out_valid || Out_ready;
  assign In_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // pa/pb: operand bits not yet added, slice k in the low W bits
    localparam int RW = DATA_WIDTH - k * W;

    logic [RW-1:0]      pa;
    logic [RW-1:0]      pb;
    logic               pc;
    logic               pv;
    logic [W-1:0]       s;
    logic               co;
    logic [(k+1)*W-1:0] nsum;
    logic [(k+1)*W-1:0] sum_q;
    logic               c_q;
    logic               v_q;

    if (k == 0) begin : g_in
      assign pa   = A;
      assign pb   = Sub ? ~B : B;
      assign pc   = Sub | Carry_in;
      assign pv   = In_valid;
      assign nsum = s;
    end else begin : g_link
      assign pa   = g_stage[k-1].g_fwd.a_q;
      assign pb   = g_stage[k-1].g_fwd.b_q;
      assign pc   = g_stage[k-1].c_q;
      assign pv   = g_stage[k-1].v_q;
      assign nsum = {s, g_stage[k-1].sum_q};
    end

    adder_slice #(.W(W)) u_slice (
      .a  (pa[W-1:0]),
      .b  (pb[W-1:0]),
      .ci (pc),
      .s  (s),
      .co (co)
    );

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (advance) begin
        v_q   <= pv;
        c_q   <= co;
        sum_q <= nsum;
      end
    end

    if (k != STAGES - 1) begin : g_fwd
      logic [RW-W-1:0] a_q;
      logic [RW-W-1:0] b_q;

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= pa[RW-1:W];
          b_q <= pb[RW-1:W];
        end
      end
    end else begin : g_ovf
      // top slice holds the operand sign bits
      logic ov_q;

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          ov_q <= 1'b0;
        end else if (advance) begin
          ov_q <= (pa[W-1] == pb[W-1]) && (s[W-1] != pa[W-1]);
        end
      end
    end
  end

  assign Sum       = g_stage[STAGES-1].sum_q;
  assign Carry_out = g_stage[STAGES-1].c_q;
  assign Overflow  = g_stage[STAGES-1].g_ovf.ov_q;
  assign Out_valid = g_stage[STAGES-1].v_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed table-driven bench for pipelined_adder.
// Covers reset, latency, streaming, backpressure and mid-flight reset.
module tb_pipelined_adder;

  localparam int DW = 16;
  localparam int ST = 4;
  localparam int NV = 12;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] A;
  logic [DW-1:0] B;
  logic          Carry_in;
  logic          Sub;
  logic          In_valid;
  logic          In_ready;
  logic [DW-1:0] Sum;
  logic          Carry_out;
  logic          Overflow;
  logic          Out_valid;
  logic          Out_ready;

  pipelined_adder #(.DATA_WIDTH(DW), .STAGES(ST)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .A         (A),
    .B         (B),
    .Carry_in  (Carry_in),
    .Sub       (Sub),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .Sum       (Sum),
    .Carry_out (Carry_out),
    .Overflow  (Overflow),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vt [NV];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int i);
    A        = vt[i].a;
    B        = vt[i].b;
    Carry_in = vt[i].cin;
    Sub      = vt[i].sub;
  endtask

  task automatic chk_out(input string tag, input int i);
    chk({tag, "_sum"}, 32'(Sum), 32'(vt[i].sum));
    chk({tag, "_co"}, 32'(Carry_out), 32'(vt[i].co));
    chk({tag, "_ov"}, 32'(Overflow), 32'(vt[i].ov));
  endtask

  // Streams vt[0..n-1]; Out_ready low for the first stall cycles.
  task automatic run_stream(input int n, input int stall,
                            output int first_out, output int last_out,
                            output int acc_at_stall);
    int q[$];
    int nxt = 0;
    int got = 0;
    int cyc = 0;
    int idx;
    logic hold_v = 1'b0;
    logic [DW-1:0] hs;
    logic hco, hov;
    bit saw_drop = 1'b0;
    first_out = -1;
    last_out = -1;
    acc_at_stall = 0;
    while (got < n && cyc < 200) begin
      Out_ready = (cyc >= stall);
      if (nxt < n) begin
        In_valid = 1'b1;
        drive(nxt);
      end else begin
        In_valid = 1'b0;
      end
      #1;
      if (hold_v) begin
        chk("hold_sum", 32'(Sum), 32'(hs));
        chk("hold_co", 32'(Carry_out), 32'(hco));
        chk("hold_ov", 32'(Overflow), 32'(hov));
      end
      if (Out_valid && !Out_ready && !saw_drop) begin
        chk("in_ready_drop", 32'(In_ready), 32'd0);
        saw_drop = 1'b1;
      end
      if (Out_valid && Out_ready) begin
        chk("out_expected", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          idx = q.pop_front();
          chk_out($sformatf("stream%0d", idx), idx);
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        got++;
      end
      hold_v = Out_valid && !Out_ready;
      hs  = Sum;
      hco = Carry_out;
      hov = Overflow;
      if (In_valid && In_ready) begin
        q.push_back(nxt);
        nxt++;
      end
      if (cyc == stall - 1) acc_at_stall = nxt;
      @(posedge CLK);
      #1;
      cyc++;
    end
    chk("stream_count", 32'(got), 32'(n));
    In_valid  = 1'b0;
    Out_ready = 1'b1;
  endtask

  initial begin
    int lat;
    int f_out, l_out, acc;
    int stale;

    vt[0]  = '{16'h0006, 16'h0001, 1'b1, 1'b0, 16'h0008, 1'b0, 1'b0};
    vt[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[4]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vt[5]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[6]  = '{16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0};
    vt[7]  = '{16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[9]  = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[10] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};
    vt[11] = '{16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0};

    RST       = 1'b0;
    A         = '0;
    B         = '0;
    Carry_in  = 1'b0;
    Sub       = 1'b0;
    In_valid  = 1'b0;
    Out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 32'(Out_valid), 32'd0);
    chk("rst_sum", 32'(Sum), 32'd0);
    chk("rst_co", 32'(Carry_out), 32'd0);
    chk("rst_ov", 32'(Overflow), 32'd0);
    chk("rst_in_ready", 32'(In_ready), 32'd1);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // single transaction latency
    In_valid = 1'b1;
    drive(0);
    lat = 0;
    do begin
      @(posedge CLK);
      #1;
      In_valid = 1'b0;
      lat++;
    end while (!Out_valid && lat < 20);
    chk("latency", 32'(lat), 32'(ST));
    chk_out("single", 0);
    @(posedge CLK);
    #1;
    chk("drained", 32'(Out_valid), 32'd0);

    // back-to-back stream at full rate
    run_stream(NV, 0, f_out, l_out, acc);
    chk("consecutive", 32'(l_out - f_out + 1), 32'(NV));

    // backpressure: pipeline fills, then drains in order
    run_stream(NV, 10, f_out, l_out, acc);
    chk("accepted_while_stalled", 32'(acc), 32'(ST));

    // reset with three transactions in flight
    for (int i = 0; i < 3; i++) begin
      In_valid = 1'b1;
      drive(i + 4);
      @(posedge CLK);
      #1;
    end
    In_valid = 1'b0;
    chk("pre_rst_sum", 32'(Sum), 32'(vt[NV-1].sum));
    RST = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(Out_valid), 32'd0);
    chk("mid_rst_sum", 32'(Sum), 32'd0);
    chk("mid_rst_co", 32'(Carry_out), 32'd0);
    chk("mid_rst_ov", 32'(Overflow), 32'd0);
    chk("mid_rst_in_ready", 32'(In_ready), 32'd1);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    stale = 0;
    repeat (10) begin
      @(posedge CLK);
      #1;
      if (Out_valid) stale++;
    end
    chk("no_stale_output", 32'(stale), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
